or_checker: RTL
===============

OR_CHECKER -- requirements
Module: or_checker

Interface
REQ-001 SHALL have parameter NUM_VEC, default 4, the number of vectors checked per run (range 1..2^CNT_W-1).
REQ-002 SHALL have parameter CNT_W, default 8, the width of the pass and fail counters.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a run.
REQ-006 SHALL have port in_valid, input, 1 bit: a, b and o hold one vector this cycle.
REQ-007 SHALL have ports a and b, input, 1 bit each: stimulus driven into the upstream OR stage.
REQ-008 SHALL have port o, input, 1 bit: output of the upstream OR stage under check.
REQ-009 SHALL have port busy, output, 1 bit: high in state RUN.
REQ-010 SHALL have port done, output, 1 bit: high in state DONE.
REQ-011 SHALL have port pass_cnt, output, CNT_W bits: count of matching vectors.
REQ-012 SHALL have port fail_cnt, output, CNT_W bits: count of mismatching vectors.
REQ-013 SHALL have port all_pass, output, 1 bit: equals done AND (fail_cnt == 0).

Function
REQ-014 SHALL implement three states: IDLE, RUN and DONE.
REQ-015 SHALL move IDLE->RUN on start=1; on the same edge it SHALL clear pass_cnt, fail_cnt and the internal vector count vec_cnt.
REQ-016 SHALL, in RUN with in_valid=1, compute exp = a|b and increment pass_cnt if o==exp, otherwise increment fail_cnt; the updated count SHALL be visible one cycle later.
REQ-017 SHALL increment vec_cnt on each accepted vector, and SHALL move RUN->DONE on the edge that accepts vector number NUM_VEC.
REQ-018 SHALL ignore in_valid in IDLE and DONE, and SHALL ignore in_valid=0 cycles in RUN.
REQ-019 SHALL ignore start while in RUN.
REQ-020 SHALL, in DONE, hold the counts, and on start=1 clear them and re-enter RUN.
REQ-021 SHALL saturate pass_cnt and fail_cnt at 2^CNT_W-1 with no wrap-around.
REQ-022 SHALL treat X/Z on o as a mismatch in simulation.
REQ-023 SHALL, when start and in_valid are both high in IDLE, accept only start; that vector is not counted.

Reset
REQ-024 SHALL, on rst_n=0, immediately force state=IDLE, busy=0, done=0, all_pass=0, pass_cnt=0, fail_cnt=0 and vec_cnt=0.
REQ-025 SHALL, on reset mid-run, abandon the run with no partial result retained; operation resumes on the first clk edge after rst_n rises.

Configuration
REQ-026 SHALL compile in first-fail capture only when macro OR_CHECKER_FIRST_FAIL_EN is defined.
REQ-027 SHALL, with OR_CHECKER_FIRST_FAIL_EN defined, add output first_fail_vld (1 bit) and output first_fail_vec (3 bits, {a,b,o}); these latch the first mismatching vector of a run, are held until the next start or reset, and reset to 0.
REQ-028 SHALL, without OR_CHECKER_FIRST_FAIL_EN defined, have neither port nor the capture logic; all other behaviour SHALL be identical.

Verification
REQ-029 SHALL cover a good run: start, then (a,b,o)=00/0, 01/1, 10/1, 11/1 -> done=1, pass_cnt=4, fail_cnt=0, all_pass=1, busy=0.
REQ-030 SHALL cover a faulty run: start, then 00/1, 01/1, 10/0, 11/1 -> pass_cnt=2, fail_cnt=2, all_pass=0; with the macro defined, first_fail_vec=3'b001.
REQ-031 SHALL cover gaps and ignored inputs: in_valid toggles 1/0 in RUN, and start is pulsed mid-run -> only valid cycles are counted, no restart occurs, and done rises after the 4th valid vector.
REQ-032 SHALL cover saturation: CNT_W=2, NUM_VEC=3, all vectors fail -> fail_cnt=3 with no wrap-around; then CNT_W=2, NUM_VEC=3 with 3 passes -> pass_cnt=3.
REQ-033 SHALL cover reset mid-run: rst_n pulsed low after 2 vectors -> all outputs are 0 immediately and state is IDLE; a new start runs cleanly from zero.
REQ-034 SHALL cover restart from DONE: start in DONE -> counts clear on the next edge, busy=1 and done=0.

Source files
------------

// File: rtl/or_checker.sv
// ---------------------------------------------------------------------------
// or_checker
//   Self-test monitor for an upstream 2-input OR stage. After a start pulse it
//   accepts NUM_VEC vectors (a, b, o) and compares o against a|b. It counts
//   matches and mismatches in saturating counters, then parks in DONE until
//   the next start.
//
// Parameters
//   NUM_VEC : vectors per run (1 .. 2^CNT_W-1)
//   CNT_W   : width of the pass/fail/vector counters
//
// Ports
//   clk, rst_n            : clock, async active-low reset
//   start                 : one-cycle run request (ignored while busy)
//   in_valid, a, b, o     : vector under check
//   busy / done           : state RUN / state DONE
//   pass_cnt / fail_cnt   : matching / mismatching vector counts
//   all_pass              : done && fail_cnt == 0
//   first_fail_vld/_vec   : first mismatching {a,b,o} of the run; these ports
//                           exist only when OR_CHECKER_FIRST_FAIL_EN is defined
// ---------------------------------------------------------------------------
module or_checker #(
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             all_pass
`ifdef OR_CHECKER_FIRST_FAIL_EN
  ,
  output logic             first_fail_vld,
  output logic [2:0]       first_fail_vec
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VEC - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_pass, r_fail, r_vec;
  logic             w_clr, w_acc, w_match;

  // An X/Z on o makes this compare X, which falls into the mismatch branch.
  assign w_match = (o == (a | b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // start outranks in_valid in IDLE/DONE, so a vector that arrives with start
  // is dropped; in RUN, start is ignored entirely.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_clr       = 1'b0;
    w_acc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clr       = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (in_valid) begin
          w_acc = 1'b1;
          if (r_vec == LAST_VEC) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_clr       = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= '0;
      r_fail <= '0;
      r_vec  <= '0;
    end else if (w_clr) begin
      r_pass <= '0;
      r_fail <= '0;
      r_vec  <= '0;
    end else if (w_acc) begin
      r_vec <= r_vec + 1'b1;
      // saturate rather than wrap
      if (w_match) begin
        if (r_pass != '1) r_pass <= r_pass + 1'b1;
      end else begin
        if (r_fail != '1) r_fail <= r_fail + 1'b1;
      end
    end
  end

  assign pass_cnt = r_pass;
  assign fail_cnt = r_fail;
  assign all_pass = done && (r_fail == '0);

`ifdef OR_CHECKER_FIRST_FAIL_EN
  logic       r_ff_vld;
  logic [2:0] r_ff_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff_vld <= 1'b0;
      r_ff_vec <= '0;
    end else if (w_clr) begin
      r_ff_vld <= 1'b0;
      r_ff_vec <= '0;
    end else if (w_acc && !w_match && !r_ff_vld) begin
      r_ff_vld <= 1'b1;
      r_ff_vec <= {a, b, o};
    end
  end

  assign first_fail_vld = r_ff_vld;
  assign first_fail_vec = r_ff_vec;
`endif

endmodule
